// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Brief    : Bimodal 2-bit branch predictor plus EX-stage next-PC/flush control.
//            A one-cycle RECOVER state squashes the wrong-path instruction.
//            Optional macro BPRED_STATS_EN enables the saturating
//            branch/mispredict counters. Without it, both ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_branch_flag,
    input  logic            ex_pred_taken,
    output logic [1:0]      branch_ctrl,
    output logic            flush,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int         IDX_W       = $clog2(BHT_ENTRIES);
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BR     = 7'b1100011;
    localparam logic [1:0] c_SEL_PC4   = 2'b00;
    localparam logic [1:0] c_SEL_JALR  = 2'b01;
    localparam logic [1:0] c_SEL_IMM   = 2'b10;
    localparam logic [1:0] c_SEL_RECOV = 2'b11;

    typedef enum logic [0:0] {
        S_NORMAL  = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    state_t           r_state_q;
    state_t           w_state_d;
    logic [1:0]       r_bht_q [BHT_ENTRIES];
    logic [1:0]       w_bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_active;
    logic             w_is_br;
    logic             w_mispred;
    logic             w_upd;
    logic             w_unused;

    // Word-aligned PCs: the two LSBs never select an entry.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    // Prediction reads the current table, so a same-cycle update is not visible yet.
    assign pred_taken = r_bht_q[w_if_idx][1];

    assign w_active  = (r_state_q == S_NORMAL) && ex_valid;
    assign w_is_br   = w_active && (ex_opcode == c_OP_BR);
    assign w_mispred = w_is_br && (ex_branch_flag != ex_pred_taken);
    assign w_upd     = w_is_br && !stall;

    // Decode the EX instruction into next-PC select and squash request.
    always_comb begin
        branch_ctrl = c_SEL_PC4;
        flush       = (r_state_q == S_RECOVER);
        if (w_active) begin
            if (ex_opcode == c_OP_JAL) begin
                branch_ctrl = c_SEL_IMM;
                flush       = 1'b1;
            end else if (ex_opcode == c_OP_JALR) begin
                branch_ctrl = c_SEL_JALR;
                flush       = 1'b1;
            end else if (w_mispred) begin
                branch_ctrl = ex_branch_flag ? c_SEL_IMM : c_SEL_RECOV;
                flush       = 1'b1;
            end
        end
    end

    // Next FSM state: one unstalled RECOVER cycle follows every unstalled flush.
    always_comb begin
        w_state_d = r_state_q;
        if (!stall) begin
            if (r_state_q == S_RECOVER) begin
                w_state_d = S_NORMAL;
            end else if (flush) begin
                w_state_d = S_RECOVER;
            end
        end
    end

    // Next BHT contents: saturating train of the resolved branch's counter.
    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            w_bht_d[i] = r_bht_q[i];
        end
        if (w_upd) begin
            if (ex_branch_flag) begin
                if (r_bht_q[w_ex_idx] != 2'b11) begin
                    w_bht_d[w_ex_idx] = r_bht_q[w_ex_idx] + 2'd1;
                end
            end else begin
                if (r_bht_q[w_ex_idx] != 2'b00) begin
                    w_bht_d[w_ex_idx] = r_bht_q[w_ex_idx] - 2'd1;
                end
            end
        end
    end

    // State and table registers; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_NORMAL;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht_q[i] <= CTR_INIT;
            end
        end else begin
            r_state_q <= w_state_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht_q[i] <= w_bht_d[i];
            end
        end
    end

`ifdef BPRED_STATS_EN
    logic [31:0] r_stat_br_q;
    logic [31:0] w_stat_br_d;
    logic [31:0] r_stat_mp_q;
    logic [31:0] w_stat_mp_d;

    // Saturating event counters for resolved and mispredicted branches.
    always_comb begin
        w_stat_br_d = r_stat_br_q;
        w_stat_mp_d = r_stat_mp_q;
        if (w_upd && (r_stat_br_q != 32'hFFFF_FFFF)) begin
            w_stat_br_d = r_stat_br_q + 32'd1;
        end
        if (w_upd && w_mispred && (r_stat_mp_q != 32'hFFFF_FFFF)) begin
            w_stat_mp_d = r_stat_mp_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br_q <= 32'd0;
            r_stat_mp_q <= 32'd0;
        end else begin
            r_stat_br_q <= w_stat_br_d;
            r_stat_mp_q <= w_stat_mp_d;
        end
    end

    assign stat_branches    = r_stat_br_q;
    assign stat_mispredicts = r_stat_mp_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC/data width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, branch history table depth; power of two, >= 2; IDX_W = log2(BHT_ENTRIES).
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, reset value of every 2-bit counter.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
REQ-005 SHALL have these other ports:
- if_pc  in  XLEN  fetch PC to look up
- pred_taken  out  1  fetch-side prediction for if_pc
- stall  in  1  pipeline stall; freezes state
- ex_valid  in  1  EX stage holds a real instruction
- ex_opcode  in  7  EX instruction opcode
- ex_pc  in  XLEN  EX instruction PC
- ex_branch_flag  in  1  resolved B-type outcome, 1 = taken
- ex_pred_taken  in  1  prediction carried down with the EX instruction
- branch_ctrl  out  2  next-PC select: 00 PC+4, 01 JALR target, 10 ex PC+imm, 11 ex_pc+4 recovery
- flush  out  1  squash younger instructions
- stat_branches  out  32  resolved B-type count
- stat_mispredicts  out  32  mispredicted B-type count

Function
REQ-006 SHALL index the BHT with idx(pc) = pc[IDX_W+1:2].
REQ-007 SHALL drive pred_taken combinationally as the MSB of counter[idx(if_pc)].
REQ-008 SHALL hold FSM states NORMAL and RECOVER; ex_* inputs are honoured only in NORMAL with ex_valid=1 ("active").
REQ-009 SHALL, when active, decode combinationally in this priority:
- JAL (1101111): branch_ctrl=10, flush=1.
- JALR (1100111): branch_ctrl=01, flush=1.
- B-type (1100011) with ex_branch_flag != ex_pred_taken: flush=1; branch_ctrl=10 if ex_branch_flag=1, else 11.
- B-type, correctly predicted: branch_ctrl=00, flush=0.
- any other opcode: branch_ctrl=00, flush=0.
REQ-010 SHALL drive branch_ctrl=00 when not active; flush=1 throughout RECOVER, else 0.
REQ-011 SHALL move NORMAL->RECOVER at the clock edge ending any cycle with flush=1 and stall=0; RECOVER->NORMAL after exactly one unstalled cycle.
REQ-012 SHALL update counter[idx(ex_pc)] at the clock edge for an active B-type with stall=0:
- increment if ex_branch_flag=1, saturating at 11.
- decrement if ex_branch_flag=0, saturating at 00.
REQ-013 SHALL give pred_taken the pre-update counter value when if_pc and ex_pc share an index in the update cycle (no bypass).
REQ-014 SHALL, with stall=1, hold FSM, BHT and statistics while outputs keep following inputs combinationally.
REQ-015 SHALL make no BHT or statistics change in RECOVER or when ex_valid=0.

Reset
REQ-016 SHALL, with rst=1 at a clock edge, set FSM=NORMAL, all counters=CTR_INIT, and statistics=0; rst overrides stall.
REQ-017 SHALL make reset outputs: flush=0 and branch_ctrl=00 when ex_valid=0; pred_taken=CTR_INIT[1].
REQ-018 SHALL, on reset asserted in RECOVER, return to NORMAL with no pending flush.

Configuration
REQ-019 SHALL, with macro BPRED_STATS_EN defined, implement stat_branches and stat_mispredicts:
- stat_branches +1 per update of REQ-012.
- stat_mispredicts +1 per mispredicted active B-type with stall=0.
- both saturate at 32'hFFFF_FFFF.
REQ-020 SHALL, without BPRED_STATS_EN, keep both ports and tie them to 0 with no counter logic.

Verification
REQ-021 SHALL check: reset, if_pc=0x100 -> pred_taken=0; B-type at ex_pc=0x100, flag=1, pred=0, twice with a RECOVER between -> each has branch_ctrl=10, flush=1; afterwards pred_taken=1 for if_pc=0x100.
REQ-022 SHALL check: B-type, flag=0, pred=1 -> branch_ctrl=11 and flush=1 that cycle and the next; an ex_valid JAL in that RECOVER cycle -> branch_ctrl=00, no update.
REQ-023 SHALL check: counter at 11 with 3 taken updates -> stays 11; counter at 00 with 3 not-taken updates -> stays 00.
REQ-024 SHALL check: stall=1 for 3 cycles during a mispredict -> flush=1 each cycle, FSM stays NORMAL, single BHT update after stall drops.
REQ-025 SHALL check: BHT_ENTRIES=16, ex_pc=0x040 and if_pc=0x000 (alias, idx 0) -> same-cycle pred_taken shows the old value and the updated value the next cycle.
REQ-026 SHALL check with BPRED_STATS_EN: 5 B-types with 2 mispredicts -> stat_branches=5, stat_mispredicts=2; rst -> both 0.
